noc_input_fifo: RTL and testbench

//  Per-input-port flit buffer of the mesh router; sits directly upstream of the route-compute (LBDR) stage.
//  - Stores incoming flits; exposes the head flit first-word-fall-through with decoded flit_id and dst_addr.
//  - Returns one credit to the upstream router per flit popped.
//  - Tracks packet framing (HEADER/BODY/TAIL) on the read side and flags protocol errors.

---
 rtl/noc_pkg.sv | 21 ++
 rtl/noc_fifo_mem.sv | 24 ++
 rtl/noc_input_fifo.sv | 133 +++++++++++++
 tb/tb_noc_input_fifo.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared types for the mesh router input buffer: flit_id codes, field offsets, framing states.
package noc_pkg;

  localparam int ADDR_W    = 4;
  localparam int FLIT_ID_W = 3;
  localparam int DST_LSB   = 0;
  localparam int SRC_LSB   = 4;

  typedef enum logic [FLIT_ID_W-1:0] {
    FLIT_HEADER      = 3'b001,
    FLIT_BODY        = 3'b010,
    FLIT_TAIL        = 3'b100,
    FLIT_HEADER_TAIL = 3'b101
  } flit_id_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } frame_state_t;

endpackage

// File: rtl/noc_fifo_mem.sv
// Flit storage: DEPTH x DATA_W register array, one synchronous write port, one combinational read port.
// Contents are deliberately not reset; the pointers in the parent decide what is valid.
module noc_fifo_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/noc_input_fifo.sv
// Router input-port flit FIFO (FWFT) with credit return, read-side framing check, optional parity (NOC_FIFO_PARITY_EN).
// Latency: write visible on rd_data the next cycle; credit_out pulses the cycle after each accepted pop.
// Backpressure: credit-based upstream; a write into a full FIFO without a same-cycle pop is dropped and flagged.
module noc_input_fifo
  import noc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    rx_data,
  input  logic                 rx_valid,
  output logic                 credit_out,
  input  logic                 rd_en,
  output logic [DATA_W-1:0]    rd_data,
  output logic [FLIT_ID_W-1:0] flit_id,
  output logic [ADDR_W-1:0]    dst_addr,
  output logic                 empty,
  output logic                 full,
  output logic [PTR_W-1:0]     occupancy,
  output logic                 overflow_err,
  output logic                 framing_err,
  output logic                 parity_err
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             credit_q, credit_d;
  logic             overflow_err_q, overflow_err_d;
  logic             framing_err_q, framing_err_d;
  frame_state_t     state_q, state_d;
  logic             wr_en, rd_ok;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                     (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);
  assign occupancy = wr_ptr_q - rd_ptr_q;

  // A full FIFO still accepts a flit when the head leaves in the same cycle.
  assign rd_ok = rd_en & ~empty;
  assign wr_en = rx_valid & (~full | rd_ok);

  noc_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q[PTR_W-2:0]),
    .wr_data (rx_data),
    .rd_addr (rd_ptr_q[PTR_W-2:0]),
    .rd_data (rd_data)
  );

  assign flit_id  = rd_data[DATA_W-1 -: FLIT_ID_W];
  assign dst_addr = rd_data[DST_LSB +: ADDR_W];

  always_comb begin
    wr_ptr_d       = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d       = rd_ptr_q + PTR_W'(rd_ok);
    credit_d       = rd_ok;
    overflow_err_d = overflow_err_q | (rx_valid & full & ~rd_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      credit_q       <= 1'b0;
      overflow_err_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      credit_q       <= credit_d;
      overflow_err_q <= overflow_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      framing_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      framing_err_q <= framing_err_d;
    end
  end

  // Framing only advances on an accepted pop; undefined codes flag an error and hold state.
  always_comb begin
    state_d       = state_q;
    framing_err_d = framing_err_q;
    if (rd_ok) begin
      case (flit_id)
        FLIT_HEADER: begin
          if (state_q == ST_IN_PKT) framing_err_d = 1'b1;
          state_d = ST_IN_PKT;
        end
        FLIT_HEADER_TAIL: begin
          if (state_q == ST_IN_PKT) framing_err_d = 1'b1;
          state_d = ST_IDLE;
        end
        FLIT_BODY: begin
          if (state_q == ST_IDLE) framing_err_d = 1'b1;
        end
        FLIT_TAIL: begin
          if (state_q == ST_IDLE) framing_err_d = 1'b1;
          state_d = ST_IDLE;
        end
        default: framing_err_d = 1'b1;
      endcase
    end
  end

`ifdef NOC_FIFO_PARITY_EN
  logic parity_err_q, parity_err_d;

  // Even parity over the whole flit; the flit is stored regardless.
  always_comb parity_err_d = parity_err_q | (wr_en & (^rx_data));

  always_ff @(posedge clk) begin
    if (rst) parity_err_q <= 1'b0;
    else     parity_err_q <= parity_err_d;
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign credit_out   = credit_q;
  assign overflow_err = overflow_err_q;
  assign framing_err  = framing_err_q;

endmodule

// File: tb/tb_noc_input_fifo.sv
// Self-checking bench for noc_input_fifo: directed scenarios plus randomized traffic against a queue model.
module tb_noc_input_fifo;
  import noc_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int OCC_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              credit_out;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic [2:0]        flit_id;
  logic [3:0]        dst_addr;
  logic              empty, full;
  logic [OCC_W-1:0]  occupancy;
  logic              overflow_err, framing_err, parity_err;

  noc_input_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .credit_out   (credit_out),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .flit_id      (flit_id),
    .dst_addr     (dst_addr),
    .empty        (empty),
    .full         (full),
    .occupancy    (occupancy),
    .overflow_err (overflow_err),
    .framing_err  (framing_err),
    .parity_err   (parity_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a flit queue plus sticky flags and a packet-open bit.
  logic [DATA_W-1:0] q[$];
  bit m_ovf, m_frm, m_par, m_inpkt, m_credit;

  function automatic void model_clear();
    q.delete();
    m_ovf = 0; m_frm = 0; m_par = 0; m_inpkt = 0; m_credit = 0;
  endfunction

  function automatic void model_frame(input logic [2:0] fid);
    if (fid == 3'b001)      begin if (m_inpkt) m_frm = 1; m_inpkt = 1; end
    else if (fid == 3'b101) begin if (m_inpkt) m_frm = 1; m_inpkt = 0; end
    else if (fid == 3'b010) begin if (!m_inpkt) m_frm = 1; end
    else if (fid == 3'b100) begin if (!m_inpkt) m_frm = 1; m_inpkt = 0; end
    else m_frm = 1;
  endfunction

  function automatic logic [DATA_W-1:0] mk(input logic [2:0] fid, input logic [3:0] dst,
                                           input bit good_par);
    logic [DATA_W-1:0] d;
    d = $urandom();
    d[31:29] = fid;
    d[3:0]   = dst;
    d[28]    = 1'b0;
    d[28]    = good_par ? (^d) : ~(^d);
    return d;
  endfunction

  // One clock: inputs applied at a negedge, model advanced, outputs valid at the next negedge.
  task automatic cycle(input bit v, input logic [DATA_W-1:0] d, input bit r);
    bit pop, wr;
    logic [DATA_W-1:0] h;
    rx_valid = v; rx_data = d; rd_en = r;
    pop = r && (q.size() != 0);
    wr  = v && ((q.size() < DEPTH) || pop);
    if (v && (q.size() == DEPTH) && !r) m_ovf = 1;
`ifdef NOC_FIFO_PARITY_EN
    if (wr && (^d)) m_par = 1;
`endif
    if (pop) begin h = q.pop_front(); model_frame(h[31:29]); end
    if (wr) q.push_back(d);
    m_credit = pop;
    @(negedge clk);
    rx_valid = 0; rd_en = 0;
  endtask

  task automatic do_reset();
    rst = 1; rx_valid = 0; rd_en = 0; rx_data = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (occupancy !== '0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    checks++; if (credit_out !== 1'b0) begin errors++; $display("FAIL reset_credit got=%b exp=0", credit_out); end
    checks++; if ({overflow_err, framing_err, parity_err} !== 3'b000) begin
      errors++; $display("FAIL reset_errs got=%b exp=000", {overflow_err, framing_err, parity_err}); end
  endtask

  task automatic test_header();
    logic [DATA_W-1:0] f;
    f = mk(3'b001, 4'h9, 1);
    rx_valid = 1; rx_data = f; rd_en = 0;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL no_bypass got_empty=%b exp=1", empty); end
    cycle(1, f, 0);
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL hdr_empty got=%b exp=0", empty); end
    checks++; if (flit_id !== 3'b001) begin errors++; $display("FAIL hdr_flit_id got=%b exp=001", flit_id); end
    checks++; if (dst_addr !== 4'h9) begin errors++; $display("FAIL hdr_dst got=%h exp=9", dst_addr); end
    checks++; if (occupancy !== 1) begin errors++; $display("FAIL hdr_occ got=%0d exp=1", occupancy); end
    checks++; if (rd_data !== f) begin errors++; $display("FAIL hdr_data got=%h exp=%h", rd_data, f); end
  endtask

  task automatic test_full_overflow();
    cycle(1, mk(3'b010, 4'h0, 1), 0);
    cycle(1, mk(3'b010, 4'h0, 1), 0);
    cycle(1, mk(3'b100, 4'h0, 1), 0);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag got=%b exp=1", full); end
    checks++; if (occupancy !== 4) begin errors++; $display("FAIL full_occ got=%0d exp=4", occupancy); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b exp=0", overflow_err); end
    cycle(1, mk(3'b001, 4'h3, 1), 0);
    checks++; if (overflow_err !== m_ovf) begin errors++; $display("FAIL ovf_set got=%b exp=%b", overflow_err, m_ovf); end
    checks++; if (occupancy !== 4) begin errors++; $display("FAIL ovf_occ got=%0d exp=4", occupancy); end
    checks++; if (rd_data !== q[0]) begin errors++; $display("FAIL ovf_head got=%h exp=%h", rd_data, q[0]); end
  endtask

  task automatic test_full_passthrough();
    logic [DATA_W-1:0] f;
    f = mk(3'b101, 4'h5, 1);
    cycle(1, f, 1);
    checks++; if (occupancy !== 4) begin errors++; $display("FAIL pass_occ got=%0d exp=4", occupancy); end
    checks++; if (credit_out !== 1'b1) begin errors++; $display("FAIL pass_credit got=%b exp=1", credit_out); end
    cycle(0, '0, 0);
    checks++; if (credit_out !== 1'b0) begin errors++; $display("FAIL pass_single_pulse got=%b exp=0", credit_out); end
    for (int i = 0; i < 3; i++) cycle(0, '0, 1);
    checks++; if (rd_data !== f) begin errors++; $display("FAIL pass_tail got=%h exp=%h", rd_data, f); end
    cycle(0, '0, 1);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL pass_drain got_empty=%b exp=1", empty); end
    checks++; if (framing_err !== m_frm) begin errors++; $display("FAIL pass_frm got=%b exp=%b", framing_err, m_frm); end
  endtask

  task automatic test_packet();
    int pulses;
    do_reset();
    cycle(1, mk(3'b001, 4'h2, 1), 0);
    cycle(1, mk(3'b010, 4'h0, 1), 0);
    cycle(1, mk(3'b010, 4'h0, 1), 0);
    cycle(1, mk(3'b100, 4'h0, 1), 0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(0, '0, (i < 4));
      if (credit_out === 1'b1) pulses++;
    end
    checks++; if (pulses != 4) begin errors++; $display("FAIL pkt_credits got=%0d exp=4", pulses); end
    checks++; if (framing_err !== 1'b0) begin errors++; $display("FAIL pkt_frm_clean got=%b exp=0", framing_err); end
    cycle(1, mk(3'b010, 4'h0, 1), 0);
    cycle(0, '0, 1);
    checks++; if (framing_err !== m_frm) begin errors++; $display("FAIL pkt_frm_body got=%b exp=%b", framing_err, m_frm); end
  endtask

  task automatic test_wrap();
    logic [DATA_W-1:0] f;
    do_reset();
    cycle(1, mk(3'b101, 4'(0), 1), 0);
    for (int i = 1; i <= 10; i++) begin
      checks++; if (rd_data !== q[0]) begin errors++; $display("FAIL wrap_order_%0d got=%h exp=%h", i, rd_data, q[0]); end
      f = mk(3'b101, 4'(i), 1);
      cycle(i < 10, f, 1);
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got=%b exp=1", empty); end
    checks++; if (occupancy !== 0) begin errors++; $display("FAIL wrap_occ got=%0d exp=0", occupancy); end
    checks++; if (framing_err !== 1'b0) begin errors++; $display("FAIL wrap_frm got=%b exp=0", framing_err); end
  endtask

  task automatic test_empty_read();
    cycle(0, '0, 1);
    checks++; if (credit_out !== 1'b0) begin errors++; $display("FAIL emptyrd_credit got=%b exp=0", credit_out); end
    checks++; if (occupancy !== 0) begin errors++; $display("FAIL emptyrd_occ got=%0d exp=0", occupancy); end
    checks++; if (framing_err !== 1'b0) begin errors++; $display("FAIL emptyrd_frm got=%b exp=0", framing_err); end
  endtask

  task automatic test_parity();
    logic [DATA_W-1:0] f;
    do_reset();
    cycle(1, mk(3'b101, 4'h1, 1), 0);
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL par_good got=%b exp=0", parity_err); end
    f = mk(3'b101, 4'h6, 0);
    cycle(1, f, 1);
    checks++; if (parity_err !== m_par) begin errors++; $display("FAIL par_bad got=%b exp=%b", parity_err, m_par); end
    checks++; if (rd_data !== f) begin errors++; $display("FAIL par_stored got=%h exp=%h", rd_data, f); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cycle(1, mk(3'b001, 4'h4, 1), 0);
    cycle(1, mk(3'b010, 4'h0, 1), 0);
    rst = 1; rd_en = 1;
    @(negedge clk);
    rst = 0; rd_en = 0;
    model_clear();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty got=%b exp=1", empty); end
    checks++; if (credit_out !== 1'b0) begin errors++; $display("FAIL rstmid_credit got=%b exp=0", credit_out); end
    cycle(1, mk(3'b101, 4'h7, 1), 0);
    cycle(0, '0, 1);
    checks++; if (framing_err !== 1'b0) begin errors++; $display("FAIL rstmid_fsm_idle got=%b exp=0", framing_err); end
  endtask

  task automatic test_random();
    logic [2:0] ids [5];
    logic [2:0] fid;
    int bad;
    ids[0] = 3'b001; ids[1] = 3'b010; ids[2] = 3'b100; ids[3] = 3'b101; ids[4] = 3'b000;
    do_reset();
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      fid = ids[$urandom_range(3, 0)];
      if ($urandom_range(19, 0) == 0) fid = 3'($urandom());
      cycle($urandom_range(2, 0) != 0, mk(fid, 4'($urandom()), $urandom_range(7, 0) != 0),
            $urandom_range(2, 0) != 0);
      if (occupancy !== OCC_W'(q.size()) || empty !== (q.size() == 0) ||
          full !== (q.size() == DEPTH) || credit_out !== m_credit ||
          overflow_err !== m_ovf || framing_err !== m_frm || parity_err !== m_par ||
          (q.size() != 0 && (rd_data !== q[0] || flit_id !== q[0][31:29] || dst_addr !== q[0][3:0])))
        bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL random_traffic bad_cycles=%0d exp=0", bad); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; rx_valid = 0; rd_en = 0; rx_data = '0;
    model_clear();
    test_reset();
    test_header();
    test_full_overflow();
    test_full_passthrough();
    test_packet();
    test_wrap();
    test_empty_read();
    test_parity();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
